// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
// Miss handler for the direct-mapped cache. On a miss it fetches the whole
// block from main memory, one read per cycle. Each returned word goes to the
// data array, and {valid,tag} is written once the last word has landed.
// fsm_busy holds the requester stalled for the whole fill.
//
// Optional build: define CRITICAL_WORD_FIRST_EN to start issue and receive
// order at the missing word (miss_address[WORD_BITS:1]) and wrap around the
// block. In the default build the order is always 0..2^WORD_BITS-1. Tag
// timing, beat count and fsm_busy are the same in both builds.
//
// state | meaning
// IDLE  | waiting for a miss; accepts one on the next edge
// FILL  | issuing reads and writing returned words into the data array
// TAG   | one cycle: write {valid,tag}; always followed by IDLE

module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [WORD_BITS-1:0]  word_num,
  output logic                  write_tag_array
);

  // Block base occupies the address bits above the word offset and byte bit.
  localparam int BASE_LSB = WORD_BITS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_next;

  logic [ADDR_WIDTH-1:BASE_LSB] base_addr;
  logic [WORD_BITS-1:0]         order_start;
  logic [WORD_BITS-1:0]         issue_cnt;
  logic [WORD_BITS-1:0]         recv_cnt;
  logic [WORD_BITS-1:0]         issue_idx;
  logic [WORD_BITS-1:0]         recv_idx;
  logic                         issue_done;
  logic                         miss_accept;
  logic                         issue_fire;
  logic                         recv_fire;
  logic                         last_beat;

`ifdef CRITICAL_WORD_FIRST_EN
  logic [WORD_BITS-1:0] start_word;
  logic                 unused_addr_lsb;

  // Remember the critical word so both issue and receive order start there.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_word <= '0;
    end else if (miss_accept) begin
      start_word <= miss_address[WORD_BITS:1];
    end
  end

  assign order_start     = start_word;
  assign unused_addr_lsb = miss_address[0];
`else
  logic unused_addr_lsb;

  assign order_start     = '0;
  assign unused_addr_lsb = ^miss_address[WORD_BITS:0];
`endif

  // Slot order is a rotation of the beat count; the add wraps within the block.
  assign issue_idx   = order_start + issue_cnt;
  assign recv_idx    = order_start + recv_cnt;

  assign miss_accept = (state == IDLE) && miss_detected;
  assign issue_fire  = (state == FILL) && !issue_done;
  assign recv_fire   = (state == FILL) && memory_data_valid;
  assign last_beat   = recv_fire && (&recv_cnt);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the block base of the accepted miss; held for the whole fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr <= '0;
    end else if (miss_accept) begin
      base_addr <= miss_address[ADDR_WIDTH-1:BASE_LSB];
    end
  end

  // Issue counter: one read per FILL cycle until the whole block is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt  <= '0;
      issue_done <= 1'b0;
    end else if (miss_accept) begin
      issue_cnt  <= '0;
      issue_done <= 1'b0;
    end else if (issue_fire) begin
      issue_cnt <= issue_cnt + 1'b1;
      if (&issue_cnt) begin
        issue_done <= 1'b1;
      end
    end
  end

  // Receive counter: advances only on beats accepted while in FILL.
  always_ff @(posedge clk) begin
    if (rst) begin
      recv_cnt <= '0;
    end else if (miss_accept) begin
      recv_cnt <= '0;
    end else if (recv_fire) begin
      recv_cnt <= recv_cnt + 1'b1;
    end
  end

  // Next-state and output decode; outputs follow state and the valid strobe.
  always_comb begin
    state_next       = state;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = {base_addr, issue_idx, 1'b0};
    write_data_array = 1'b0;
    word_num         = recv_idx;
    write_tag_array  = 1'b0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_next = FILL;
        end
      end

      FILL: begin
        fsm_busy         = 1'b1;
        mem_read_en      = issue_fire;
        write_data_array = recv_fire;
        if (last_beat) begin
          state_next = TAG;
        end
      end

      TAG: begin
        // Back to IDLE unconditionally, so the cache re-checks hit/miss
        // before any further miss is accepted.
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        state_next      = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
